// File: rtl/bsg_cache_sbuf_ctrl_if.sv
// Handshake and datapath-control bundle for the two-entry store-buffer
// controller. The controller takes the slave side; the producer/consumer
// and the external storage datapath take the master side.
interface bsg_cache_sbuf_ctrl_if;
   logic       v_i;
   logic       ready_o;
   logic       v_o;
   logic       yumi_i;
   logic       el0_en_o;
   logic       el1_en_o;
   logic       mux0_sel_o;
   logic       mux1_sel_o;
   logic       el0_valid_o;
   logic       el1_valid_o;
   logic [1:0] count_o;
   logic       empty_o;
   logic       full_o;

   modport slave (
      input  v_i, yumi_i,
      output ready_o, v_o, el0_en_o, el1_en_o, mux0_sel_o, mux1_sel_o,
             el0_valid_o, el1_valid_o, count_o, empty_o, full_o
   );

   modport master (
      output v_i, yumi_i,
      input  ready_o, v_o, el0_en_o, el1_en_o, mux0_sel_o, mux1_sel_o,
             el0_valid_o, el1_valid_o, count_o, empty_o, full_o
   );
endinterface

// File: rtl/bsg_cache_sbuf_ctrl.sv
// Control for a two-entry store buffer whose storage lives outside this
// block. el1 is the head register, el0 the tail; data_o is muxed between
// el1 and data_i.
// Optional feature: define BSG_CACHE_SBUF_CTRL_BYPASS_EN to let data_i flow
// straight to data_o while empty (zero-latency pass-through).
module bsg_cache_sbuf_ctrl #(
   parameter bit harden_full_p = 1'b0
) (
   input  logic                        clk_i,
   input  logic                        reset_i,
   bsg_cache_sbuf_ctrl_if.slave        sb
);

   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      ONE   = 2'd1,
      TWO   = 2'd2
   } state_e;

   state_e state, state_n;

   logic ready, v, el0_en, el1_en, mux0_sel, mux1_sel;

   // Occupancy register; reset discards anything in flight.
   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) state <= EMPTY;
      else         state <= state_n;
   end

   // Next state plus enables/selects, combinational from state, v_i, yumi_i.
   // Everything is held low while reset is asserted.
   always_comb begin
      state_n  = state;
      ready    = 1'b0;
      v        = 1'b0;
      el0_en   = 1'b0;
      el1_en   = 1'b0;
      mux0_sel = 1'b0;
      mux1_sel = 1'b0;
      if (!reset_i) begin
         unique case (state)
            EMPTY: begin
               ready = 1'b1;
`ifdef BSG_CACHE_SBUF_CTRL_BYPASS_EN
               // Head comes straight from data_i; a same-cycle take
               // consumes it without touching storage.
               v = sb.v_i;
               if (sb.v_i && !sb.yumi_i) begin
                  el1_en  = 1'b1;
                  state_n = ONE;
               end
`else
               if (sb.v_i) begin
                  el1_en  = 1'b1;
                  state_n = ONE;
               end
`endif
            end
            ONE: begin
               ready    = 1'b1;
               v        = 1'b1;
               mux1_sel = 1'b1;
               if (sb.v_i && sb.yumi_i) begin
                  // Head leaves, new entry replaces it directly.
                  el1_en = 1'b1;
               end else if (sb.v_i) begin
                  el0_en  = 1'b1;
                  state_n = TWO;
               end else if (sb.yumi_i) begin
                  state_n = EMPTY;
               end
            end
            TWO: begin
               ready    = harden_full_p ? sb.yumi_i : 1'b0;
               v        = 1'b1;
               mux1_sel = 1'b1;
               if (sb.yumi_i) begin
                  // Tail shifts into head; tail reloads if also enqueuing.
                  el1_en   = 1'b1;
                  mux0_sel = 1'b1;
                  if (sb.v_i && ready) el0_en = 1'b1;
                  else                 state_n = ONE;
               end
            end
            default: state_n = EMPTY;
         endcase
      end
   end

   assign sb.ready_o     = ready;
   assign sb.v_o         = v;
   assign sb.el0_en_o    = el0_en;
   assign sb.el1_en_o    = el1_en;
   assign sb.mux0_sel_o  = mux0_sel;
   assign sb.mux1_sel_o  = mux1_sel;
   assign sb.count_o     = state;
   assign sb.el1_valid_o = (state != EMPTY);
   assign sb.el0_valid_o = (state == TWO);
   assign sb.empty_o     = (state == EMPTY);
   assign sb.full_o      = (state == TWO);

endmodule

// File: tb/tb_bsg_cache_sbuf_ctrl.sv
// Bench for bsg_cache_sbuf_ctrl: two instances (harden_full_p 0 and 1), a
// behavioural storage datapath per instance, and a queue scoreboard.
module tb_bsg_cache_sbuf_ctrl;

`ifdef BSG_CACHE_SBUF_CTRL_BYPASS_EN
   localparam bit BYP = 1'b1;
`else
   localparam bit BYP = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   bsg_cache_sbuf_ctrl_if if0 ();
   bsg_cache_sbuf_ctrl_if if1 ();

   bsg_cache_sbuf_ctrl #(.harden_full_p(1'b0)) dut0 (.clk_i(clk), .reset_i(rst), .sb(if0));
   bsg_cache_sbuf_ctrl #(.harden_full_p(1'b1)) dut1 (.clk_i(clk), .reset_i(rst), .sb(if1));

   int vecs = 0;
   int errs = 0;

   // Storage datapath driven by the controller's enables and selects.
   logic [15:0] d0, d1, el0_0, el1_0, el0_1, el1_1, dout0, dout1;
   always @(posedge clk) begin
      if (if0.el0_en_o) el0_0 <= d0;
      if (if0.el1_en_o) el1_0 <= if0.mux0_sel_o ? el0_0 : d0;
      if (if1.el0_en_o) el0_1 <= d1;
      if (if1.el1_en_o) el1_1 <= if1.mux0_sel_o ? el0_1 : d1;
   end
   assign dout0 = if0.mux1_sel_o ? el1_0 : d0;
   assign dout1 = if1.mux1_sel_o ? el1_1 : d1;

   logic [15:0] q0[$];
   logic [15:0] q1[$];
   always @(posedge rst) begin
      q0.delete();
      q1.delete();
   end

   // Scoreboard for instance 0: push on accept, pop and compare on take.
   always @(negedge clk) begin
      int sz;
      logic [15:0] exp;
      #2;
      if (!rst) begin
         sz = q0.size();
         vecs++;
         if (if0.count_o !== 2'(sz)) begin
            errs++; $display("FAIL sb0_count got %0d want %0d", if0.count_o, sz);
         end
         vecs++;
         if (if0.v_o !== ((sz != 0) || (BYP && if0.v_i))) begin
            errs++; $display("FAIL sb0_v_o got %b sz %0d", if0.v_o, sz);
         end
         vecs++;
         if (if0.ready_o !== (sz < 2)) begin
            errs++; $display("FAIL sb0_ready got %b sz %0d", if0.ready_o, sz);
         end
         vecs++;
         if (if0.mux0_sel_o && !if0.el1_en_o) begin
            errs++; $display("FAIL sb0_mux0_dc got 1 want 0");
         end
         if (if0.v_i && if0.ready_o) q0.push_back(d0);
         if (if0.yumi_i && if0.v_o) begin
            vecs++;
            if (q0.size() == 0) begin
               errs++; $display("FAIL sb0_underflow got take want none");
            end else begin
               exp = q0.pop_front();
               if (dout0 !== exp) begin
                  errs++; $display("FAIL sb0_data got %h want %h", dout0, exp);
               end
            end
         end
      end
   end

   // Scoreboard for instance 1 (hardened full: ready follows yumi when full).
   always @(negedge clk) begin
      int sz;
      logic [15:0] exp;
      #2;
      if (!rst) begin
         sz = q1.size();
         vecs++;
         if (if1.count_o !== 2'(sz)) begin
            errs++; $display("FAIL sb1_count got %0d want %0d", if1.count_o, sz);
         end
         vecs++;
         if (if1.v_o !== ((sz != 0) || (BYP && if1.v_i))) begin
            errs++; $display("FAIL sb1_v_o got %b sz %0d", if1.v_o, sz);
         end
         vecs++;
         if (if1.ready_o !== ((sz < 2) || if1.yumi_i)) begin
            errs++; $display("FAIL sb1_ready got %b sz %0d", if1.ready_o, sz);
         end
         vecs++;
         if (if1.mux0_sel_o && !if1.el1_en_o) begin
            errs++; $display("FAIL sb1_mux0_dc got 1 want 0");
         end
         if (if1.v_i && if1.ready_o) q1.push_back(d1);
         if (if1.yumi_i && if1.v_o) begin
            vecs++;
            if (q1.size() == 0) begin
               errs++; $display("FAIL sb1_underflow got take want none");
            end else begin
               exp = q1.pop_front();
               if (dout1 !== exp) begin
                  errs++; $display("FAIL sb1_data got %h want %h", dout1, exp);
               end
            end
         end
      end
   end

   task automatic drive0(input logic v, input logic y, input logic [15:0] d);
      @(negedge clk);
      if0.v_i = v; if0.yumi_i = y; d0 = d;
      #1;
   endtask

   task automatic drive1(input logic v, input logic y, input logic [15:0] d);
      @(negedge clk);
      if1.v_i = v; if1.yumi_i = y; d1 = d;
      #1;
   endtask

   task automatic test_reset();
      #1;
      vecs++;
      if ({if0.count_o, if0.empty_o, if0.full_o, if0.el0_valid_o, if0.el1_valid_o} !== 6'b00_1000) begin
         errs++; $display("FAIL reset_state got %b want 001000",
            {if0.count_o, if0.empty_o, if0.full_o, if0.el0_valid_o, if0.el1_valid_o});
      end
      vecs++;
      if ({if0.ready_o, if0.v_o, if0.el0_en_o, if0.el1_en_o, if0.mux0_sel_o, if0.mux1_sel_o,
           if1.ready_o, if1.v_o} !== 8'b0) begin
         errs++; $display("FAIL reset_outs got %b want 0",
            {if0.ready_o, if0.v_o, if0.el0_en_o, if0.el1_en_o, if0.mux0_sel_o, if0.mux1_sel_o,
             if1.ready_o, if1.v_o});
      end
   endtask

   task automatic test_enq_one();
      drive0(1'b1, 1'b0, 16'hA5A5);
      vecs++;
      if ({if0.ready_o, if0.el1_en_o, if0.mux0_sel_o, if0.el0_en_o} !== 4'b1100) begin
         errs++; $display("FAIL enq_one_en got %b want 1100",
            {if0.ready_o, if0.el1_en_o, if0.mux0_sel_o, if0.el0_en_o});
      end
      drive0(1'b0, 1'b0, 16'h0);
      vecs++;
      if ({if0.count_o, if0.v_o, if0.mux1_sel_o} !== 4'b0111 || dout0 !== 16'hA5A5) begin
         errs++; $display("FAIL enq_one_head got %b/%h want 0111/a5a5",
            {if0.count_o, if0.v_o, if0.mux1_sel_o}, dout0);
      end
      drive0(1'b0, 1'b1, 16'h0);
      drive0(1'b0, 1'b0, 16'h0);
   endtask

   task automatic test_full();
      drive0(1'b1, 1'b0, 16'h1111);
      drive0(1'b1, 1'b0, 16'h2222);
      drive0(1'b1, 1'b0, 16'h9999);
      vecs++;
      if ({if0.count_o, if0.full_o, if0.ready_o, if0.el0_en_o, if0.el1_en_o} !== 6'b10_1000) begin
         errs++; $display("FAIL full_state got %b want 101000",
            {if0.count_o, if0.full_o, if0.ready_o, if0.el0_en_o, if0.el1_en_o});
      end
      drive0(1'b0, 1'b1, 16'h0);
      vecs++;
      if ({if0.el1_en_o, if0.mux0_sel_o, if0.el0_en_o} !== 3'b110 || dout0 !== 16'h1111) begin
         errs++; $display("FAIL full_deq got %b/%h want 110/1111",
            {if0.el1_en_o, if0.mux0_sel_o, if0.el0_en_o}, dout0);
      end
      drive0(1'b0, 1'b0, 16'h0);
      vecs++;
      if (dout0 !== 16'h2222 || if0.count_o !== 2'd1) begin
         errs++; $display("FAIL full_next got %h/%0d want 2222/1", dout0, if0.count_o);
      end
      drive0(1'b0, 1'b1, 16'h0);
      drive0(1'b0, 1'b0, 16'h0);
   endtask

   task automatic test_harden();
      drive1(1'b1, 1'b0, 16'h1111);
      drive1(1'b1, 1'b0, 16'h2222);
      drive1(1'b1, 1'b0, 16'h7777);
      vecs++;
      if (if1.ready_o !== 1'b0 || if1.full_o !== 1'b1) begin
         errs++; $display("FAIL hard_full got %b%b want 01", if1.ready_o, if1.full_o);
      end
      drive1(1'b1, 1'b1, 16'h3333);
      vecs++;
      if ({if1.ready_o, if1.el1_en_o, if1.el0_en_o, if1.mux0_sel_o} !== 4'b1111) begin
         errs++; $display("FAIL hard_swap got %b want 1111",
            {if1.ready_o, if1.el1_en_o, if1.el0_en_o, if1.mux0_sel_o});
      end
      drive1(1'b0, 1'b1, 16'h0);
      vecs++;
      if (if1.count_o !== 2'd2 || dout1 !== 16'h2222) begin
         errs++; $display("FAIL hard_order1 got %0d/%h want 2/2222", if1.count_o, dout1);
      end
      drive1(1'b0, 1'b1, 16'h0);
      vecs++;
      if (dout1 !== 16'h3333) begin
         errs++; $display("FAIL hard_order2 got %h want 3333", dout1);
      end
      drive1(1'b0, 1'b0, 16'h0);
   endtask

   task automatic test_bypass();
      drive0(1'b1, 1'b1, 16'h5A5A);
      vecs++;
      if ({if0.v_o, if0.mux1_sel_o, if0.el0_en_o, if0.el1_en_o} !== {BYP, 1'b0, 1'b0, !BYP}) begin
         errs++; $display("FAIL bypass_outs got %b want %b",
            {if0.v_o, if0.mux1_sel_o, if0.el0_en_o, if0.el1_en_o}, {BYP, 1'b0, 1'b0, !BYP});
      end
      vecs++;
      if (BYP && dout0 !== 16'h5A5A) begin
         errs++; $display("FAIL bypass_data got %h want 5a5a", dout0);
      end
      drive0(1'b0, 1'b0, 16'h0);
      vecs++;
      if (if0.count_o !== (BYP ? 2'd0 : 2'd1)) begin
         errs++; $display("FAIL bypass_count got %0d want %0d", if0.count_o, BYP ? 0 : 1);
      end
      if (!BYP) begin
         drive0(1'b0, 1'b1, 16'h0);
         drive0(1'b0, 1'b0, 16'h0);
      end
   endtask

   task automatic test_back_to_back();
      drive0(1'b1, 1'b0, 16'hB000);
      for (int i = 1; i < 5; i++) begin
         drive0(1'b1, 1'b1, 16'hB000 + 16'(i));
         vecs++;
         if (if0.count_o !== 2'd1 || dout0 !== 16'hB000 + 16'(i - 1)) begin
            errs++; $display("FAIL b2b_%0d got %0d/%h want 1/%h",
               i, if0.count_o, dout0, 16'hB000 + 16'(i - 1));
         end
      end
      drive0(1'b0, 1'b1, 16'h0);
      drive0(1'b0, 1'b0, 16'h0);
   endtask

   task automatic test_async_reset();
      drive0(1'b1, 1'b0, 16'hC001);
      drive0(1'b1, 1'b0, 16'hC002);
      drive0(1'b0, 1'b0, 16'h0);
      rst = 1'b1;
      #1;
      vecs++;
      if ({if0.count_o, if0.full_o, if0.empty_o, if0.ready_o, if0.v_o, if0.el0_valid_o,
           if0.el1_valid_o} !== 8'b00_010000) begin
         errs++; $display("FAIL areset got %b want 00010000",
            {if0.count_o, if0.full_o, if0.empty_o, if0.ready_o, if0.v_o, if0.el0_valid_o,
             if0.el1_valid_o});
      end
      @(negedge clk);
      rst = 1'b0;
      #1;
      vecs++;
      if (if0.ready_o !== 1'b1 || if0.empty_o !== 1'b1) begin
         errs++; $display("FAIL areset_rel got %b%b want 11", if0.ready_o, if0.empty_o);
      end
      drive0(1'b1, 1'b0, 16'hC003);
      drive0(1'b0, 1'b0, 16'h0);
      vecs++;
      if (if0.count_o !== 2'd1 || dout0 !== 16'hC003) begin
         errs++; $display("FAIL areset_enq got %0d/%h want 1/c003", if0.count_o, dout0);
      end
      drive0(1'b0, 1'b1, 16'h0);
      drive0(1'b0, 1'b0, 16'h0);
   endtask

   task automatic test_random();
      for (int c = 0; c < 10000; c++) begin
         @(negedge clk);
         if0.v_i = 1'($urandom); if0.yumi_i = 1'($urandom); d0 = 16'($urandom);
         if1.v_i = 1'($urandom); if1.yumi_i = 1'($urandom); d1 = 16'($urandom);
      end
      @(negedge clk);
      if0.v_i = 1'b0; if1.v_i = 1'b0; if0.yumi_i = 1'b1; if1.yumi_i = 1'b1;
      for (int c = 0; c < 4; c++) @(negedge clk);
      if0.yumi_i = 1'b0; if1.yumi_i = 1'b0;
      #1;
      vecs++;
      if (if0.empty_o !== 1'b1 || if1.empty_o !== 1'b1) begin
         errs++; $display("FAIL rand_drain got %b%b want 11", if0.empty_o, if1.empty_o);
      end
   endtask

   initial begin
      if0.v_i = 1'b0; if0.yumi_i = 1'b0; d0 = '0;
      if1.v_i = 1'b0; if1.yumi_i = 1'b0; d1 = '0;
      test_reset();
      @(negedge clk);
      rst = 1'b0;
      test_enq_one();
      test_full();
      test_harden();
      test_bypass();
      test_back_to_back();
      test_async_reset();
      test_random();
      @(negedge clk);
      $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
      $finish;
   end

endmodule

// File: doc/bsg_cache_sbuf_ctrl.md
BSG_CACHE_SBUF_CTRL -- requirements
Module: bsg_cache_sbuf_ctrl

Interface
REQ-001 SHALL provide parameter: harden_full_p, default 0, 0 = ready_o low whenever full; 1 = ready_o also high when full and yumi_i high (dequeue-enqueue same cycle).
REQ-002 SHALL provide port: clk_i  input  1  sole clock, all state on rising edge.
REQ-003 SHALL provide port: reset_i  input  1  asynchronous, active-high reset.
REQ-004 SHALL provide port: v_i  input  1  enqueue request; data_i on the datapath is valid.
REQ-005 SHALL provide port: ready_o  output  1  enqueue accepted this cycle when v_i & ready_o.
REQ-006 SHALL provide port: v_o  output  1  head entry valid on datapath data_o.
REQ-007 SHALL provide port: yumi_i  input  1  consumer takes head this cycle; legal only when v_o.
REQ-008 SHALL provide port: el0_en_o  output  1  write enable, tail storage element (el0 <= data_i).
REQ-009 SHALL provide port: el1_en_o  output  1  write enable, head storage element.
REQ-010 SHALL provide port: mux0_sel_o  output  1  head write source: 1 = el0, 0 = data_i.
REQ-011 SHALL provide port: mux1_sel_o  output  1  data_o source: 1 = el1, 0 = data_i.
REQ-012 SHALL provide port: el0_valid_o  output  1  el0 holds live entry (snoop qualifier).
REQ-013 SHALL provide port: el1_valid_o  output  1  el1 holds live entry (snoop qualifier).
REQ-014 SHALL provide port: count_o  output  2  occupancy, 0..2.
REQ-015 SHALL provide ports: empty_o, full_o  output  1 each  count_o==0, count_o==2.

Function
REQ-016 SHALL define enq = v_i & ready_o, deq = yumi_i & v_o; yumi_i without v_o and v_i without ready_o SHALL be ignored (no state change).
REQ-017 SHALL hold state EMPTY(0), ONE(1), TWO(2); el1_valid_o = count>=1, el0_valid_o = count==2.
REQ-018 EMPTY: mux1_sel_o=0, ready_o=1, v_o=0 (see REQ-027); enq -> el1_en_o=1, mux0_sel_o=0, next ONE.
REQ-019 ONE: mux1_sel_o=1, v_o=1, ready_o=1; enq only -> el0_en_o=1, next TWO; deq only -> no writes, next EMPTY; enq+deq -> el1_en_o=1, mux0_sel_o=0, stay ONE.
REQ-020 TWO: mux1_sel_o=1, v_o=1, ready_o = harden_full_p ? yumi_i : 0; deq only -> el1_en_o=1, mux0_sel_o=1, next ONE; deq+enq -> el1_en_o=1, mux0_sel_o=1, el0_en_o=1, stay TWO.
REQ-021 All enable/select outputs SHALL be combinational from state, v_i, yumi_i; enables low in every case not listed above.
REQ-022 mux0_sel_o SHALL be 0 whenever el1_en_o=0 (don't-care driven low).
REQ-023 Order SHALL be FIFO: entry accepted first SHALL appear on data_o first.
REQ-024 count_o SHALL never exceed 2 nor underflow below 0.

Reset
REQ-025 reset_i high SHALL asynchronously force EMPTY: count_o=0, el0/el1_valid_o=0, empty_o=1, full_o=0.
REQ-026 While reset_i high: ready_o=0, v_o=0, all enables 0, mux selects 0; entries in flight at reset SHALL be discarded; first enq accepted on the first edge after deassertion.

Configuration
REQ-027 Macro BSG_CACHE_SBUF_CTRL_BYPASS_EN defined: in EMPTY, v_o = v_i (data_o=data_i); enq+deq in EMPTY SHALL write nothing and stay EMPTY.
REQ-028 Macro undefined: in EMPTY v_o=0; yumi_i ignored; data becomes visible one cycle after enq.

Verification
REQ-029 Reset, then v_i=1 with 0xA5A5 for one cycle, yumi_i=0 -> el1_en_o=1, mux0_sel_o=0 that cycle; next cycle count_o=1, v_o=1, mux1_sel_o=1.
REQ-030 Enqueue 0x1111 then 0x2222, no yumi -> count_o=2, full_o=1, ready_o=0 (harden_full_p=0); yumi_i -> el1_en_o=1, mux0_sel_o=1, data_o next cycle 0x2222.
REQ-031 harden_full_p=1, full, v_i=1 data 0x3333 and yumi_i=1 -> el1_en_o=el0_en_o=mux0_sel_o=1, count stays 2, dequeue order 0x2222 then 0x3333.
REQ-032 BYPASS_EN defined, EMPTY, v_i=1 data 0x5A5A, yumi_i=1 -> v_o=1, mux1_sel_o=0, no enables, count_o stays 0; undefined -> v_o=0, count_o=1 next cycle.
REQ-033 count_o=2, assert reset_i mid-cycle -> outputs clear immediately without clock edge; after release ready_o=1, empty_o=1.
REQ-034 Random v_i/yumi_i for 10000 cycles against scoreboard -> FIFO order preserved, no overflow/underflow, yumi_i while v_o=0 has no effect.
